// File: rtl/regdump_reader.sv
// Register-file dump streamer: reads 2**NB_ADDR words and emits them LSB-byte-first on a valid/ready byte stream.
// Optional macro REGDUMP_HEADER_EN prepends a single 8'hA5 header byte to every dump.
module regdump_reader #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_ADDR-1:0] o_rd_addr,
  input  logic [NB_DATA-1:0] i_rd_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready
);

  // Stream handshake: a byte moves only on a cycle with o_tx_valid=1 and i_tx_ready=1;
  // once raised, o_tx_valid and o_tx_data stay stable until that transfer (or reset).

  localparam int NB_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [NB_BYTE-1:0] HDR_BYTE = NB_BYTE'(8'hA5);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_LOAD   = 3'd2,
    S_SEND   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [NB_DATA-1:0]   r_shift;
  logic [NB_CNT-1:0]    r_cnt;
  logic [NB_ADDR-1:0]   r_addr;
  logic                 w_xfer;
  logic                 w_last_byte;
  logic                 w_last_addr;

  assign w_xfer      = o_tx_valid && i_tx_ready;
  assign w_last_byte = (r_cnt == NB_CNT'(NB_BYTES - 1));
  assign w_last_addr = (r_addr == {NB_ADDR{1'b1}});
  assign o_rd_addr   = r_addr;

  always_ff @(posedge clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
`ifdef REGDUMP_HEADER_EN
          w_next = S_HEADER;
`else
          w_next = S_LOAD;
`endif
        end
      end
      S_HEADER: if (w_xfer) w_next = S_LOAD;
      S_LOAD:   w_next = S_SEND;
      S_SEND: begin
        if (w_xfer && w_last_byte) w_next = w_last_addr ? S_DONE : S_LOAD;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (r_state != S_IDLE);
    o_done     = (r_state == S_DONE);
    o_tx_valid = (r_state == S_SEND) || (r_state == S_HEADER);
    o_tx_data  = '0;
    if (r_state == S_SEND)        o_tx_data = r_shift[NB_BYTE-1:0];
    else if (r_state == S_HEADER) o_tx_data = HDR_BYTE;
  end

  // Address only advances on the final byte of a word, so it is stable across LOAD and SEND.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_shift <= i_rd_data;
          r_cnt   <= '0;
        end
        S_SEND: begin
          if (w_xfer) begin
            r_shift <= r_shift >> NB_BYTE;
            r_cnt   <= r_cnt + NB_CNT'(1);
            if (w_last_byte && !w_last_addr) r_addr <= r_addr + NB_ADDR'(1);
          end
        end
        S_DONE:  r_addr <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/regdump_reader.md
REGDUMP_READER -- requirements
Module: regdump_reader

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, register word width in bits.
REQ-002 SHALL have parameter NB_ADDR, default 5, register address width (2**NB_ADDR registers dumped).
REQ-003 SHALL have parameter NB_BYTE, default 8, output stream byte width.
REQ-004 SHALL have ports, in this order:
- clk  input  1  single clock; all state changes on posedge.
- i_rst  input  1  reset, synchronous, active-high.
- i_start  input  1  dump request, sampled in IDLE only.
- o_busy  output  1  high from the cycle after start is accepted until DONE is left.
- o_done  output  1  one-cycle pulse at dump completion.
- o_rd_addr  output  NB_ADDR  register file read address.
- i_rd_data  input  NB_DATA  register file read data, combinational from o_rd_addr in the same cycle.
- o_tx_data  output  NB_BYTE  byte to transmitter.
- o_tx_valid  output  1  o_tx_data valid.
- i_tx_ready  input  1  transmitter accepts the byte.

Function
REQ-005 SHALL implement FSM states IDLE, HEADER, LOAD, SEND, DONE.
REQ-006 IDLE: o_rd_addr=0, o_tx_valid=0; i_start=1 SHALL move to LOAD (HEADER if REGDUMP_HEADER_EN).
REQ-007 LOAD: SHALL last exactly one cycle; latch i_rd_data at current o_rd_addr into a shift register; clear byte counter; move to SEND.
REQ-008 SEND: o_tx_valid=1; o_tx_data = shift register bits [NB_BYTE-1:0] (least significant byte first).
REQ-009 A transfer SHALL occur only on a cycle with o_tx_valid=1 and i_tx_ready=1; on transfer the shift register shifts right by NB_BYTE and the byte counter increments.
REQ-010 While o_tx_valid=1 and i_tx_ready=0, o_tx_data and o_tx_valid SHALL hold stable; o_tx_valid SHALL never drop without a transfer (except on reset).
REQ-011 After transfer of byte NB_DATA/NB_BYTE-1: if o_rd_addr = 2**NB_ADDR-1, move to DONE; else increment o_rd_addr and move to LOAD.
REQ-012 DONE: SHALL last one cycle with o_done=1, o_tx_valid=0, then return to IDLE with o_rd_addr=0.
REQ-013 i_start SHALL be ignored in every state except IDLE; no queuing.
REQ-014 Register 0 SHALL be dumped like any other address (no forced zero).
REQ-015 Latency with i_tx_ready held 1, header disabled: i_start at edge k -> first o_tx_valid at cycle k+2; 5 cycles per register; o_done high at cycle k+161.
REQ-016 o_rd_addr SHALL be held constant through LOAD and SEND of a register; no wrap beyond 2**NB_ADDR-1.
REQ-017 NB_DATA SHALL be an integer multiple of NB_BYTE; other values unsupported.

Reset
REQ-018 i_rst=1 at a posedge SHALL, in any state including mid-transfer, set state IDLE, o_rd_addr=0, o_tx_valid=0, o_tx_data=0, o_busy=0, o_done=0, clear shift register and byte counter.
REQ-019 Reset SHALL take priority over i_start and i_tx_ready on the same edge; an interrupted dump SHALL NOT produce o_done.

Configuration
REQ-020 Macro REGDUMP_HEADER_EN SHALL control a header byte.
REQ-021 With REGDUMP_HEADER_EN defined: start moves to HEADER, which drives o_tx_valid=1, o_tx_data=8'hA5 under REQ-009/010 rules, then LOAD; dump = 1+4*2**NB_ADDR bytes (129 at defaults).
REQ-022 Without it: HEADER state absent/unreachable; dump = 4*2**NB_ADDR bytes (128 at defaults).

Verification
REQ-023 Model reg[i]=32'h1000_0000+i, ready=1, start pulse -> 128 bytes, first four 00,00,00,10, last four 1F,00,00,10; o_done single pulse 161 cycles after start edge.
REQ-024 Same model, i_tx_ready random 30% duty -> byte sequence identical to REQ-023; o_tx_data never changes while valid=1 and ready=0.
REQ-025 i_start pulses at cycles 10 and 40 of a dump -> exactly 128 bytes, one o_done.
REQ-026 i_rst=1 after byte 50 accepted with ready=0 -> next cycle o_tx_valid=0, o_busy=0, o_rd_addr=0, no o_done; new start -> full 128-byte dump from reg 0.
REQ-027 REGDUMP_HEADER_EN defined, ready=1 -> first byte A5, then REQ-023 sequence, 129 bytes total, o_done at cycle k+162.
